// File: rtl/bsg_fpu_normalize_serial.sv
// Iterative left-normalizer for FPU mantissas.
// Shifts an unsigned mantissa left by up to step_p positions per cycle until
// its MSB is set, reporting the total shift (leading-zero count) and whether
// the operand was all zeros. Ready/valid on the input, valid/yumi on the output.
module bsg_fpu_normalize_serial #(
    parameter int width_p = 32,
    parameter int step_p  = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic [$clog2(width_p+1)-1:0] shamt_o,
    output logic                         zero_o,
    input  logic                         yumi_i
);

    localparam int SW  = $clog2(width_p+1);
    localparam int LZW = $clog2(step_p+1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [width_p-1:0] data_reg;
    logic [SW-1:0]      shamt_reg;
    logic               zero_reg;
    logic               v_reg;

    // Top window of the working mantissa examined each SHIFT cycle.
    logic [step_p-1:0]  top_window;
    logic [step_p-1:0]  prefix_zero;
    logic [LZW-1:0]     lz;
    logic               lz_saturated;

    assign top_window = data_reg[width_p-1 -: step_p];

    // prefix_zero[gi] is set when the top gi+1 bits of the window are all zero;
    // the flags are monotone, so their population count is the leading-zero count.
    for (genvar gi = 0; gi < step_p; gi++) begin : g_prefix
        assign prefix_zero[gi] = ~|top_window[step_p-1 -: gi+1];
    end

    // Sum the prefix flags into the saturating leading-zero count.
    always_comb begin
        lz = '0;
        for (int i = 0; i < step_p; i++) begin
            lz = lz + LZW'(prefix_zero[i]);
        end
    end

    assign lz_saturated = (lz == LZW'(step_p));

    // Control and datapath state: accept, shift in step_p-bit strides, hold result.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            shamt_reg <= '0;
            zero_reg  <= 1'b0;
            v_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (v_i) begin
                        data_reg <= data_i;
                        if (data_i == '0) begin
                            zero_reg  <= 1'b1;
                            shamt_reg <= SW'(width_p);
                            v_reg     <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            zero_reg  <= 1'b0;
                            shamt_reg <= '0;
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // A nonzero operand always has a 1 inside the width, so the
                    // accumulated shift stays below width_p and nothing is lost.
                    data_reg  <= data_reg << lz;
                    shamt_reg <= shamt_reg + SW'(lz);
                    if (!lz_saturated) begin
                        v_reg     <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (yumi_i) begin
                        v_reg     <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    v_reg     <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready depends only on state; it is held low while reset is asserted.
    assign ready_o = (state_reg == ST_IDLE) && reset_n_i;
    assign v_o     = v_reg;
    assign data_o  = data_reg;
    assign shamt_o = shamt_reg;
    assign zero_o  = zero_reg;

endmodule

// File: tb/tb_bsg_fpu_normalize_serial.sv
// Directed testbench for bsg_fpu_normalize_serial (width_p=32, step_p=8).
module tb_bsg_fpu_normalize_serial;

    logic        clk_i;
    logic        reset_n_i;
    logic        v_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] data_o;
    logic [5:0]  shamt_o;
    logic        zero_o;
    logic        yumi_i;

    int errors = 0;
    int checks = 0;

    bsg_fpu_normalize_serial #(.width_p(32), .step_p(8)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .shamt_o   (shamt_o),
        .zero_o    (zero_o),
        .yumi_i    (yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one operand, return the number of edges (counting the accept edge
    // as 1) until v_o is seen high; -1 if it never appears within the budget.
    task automatic launch(input logic [31:0] d, output int lat, output logic rdy);
        rdy    = ready_o;
        v_i    = 1'b1;
        data_i = d;
        tick();
        v_i    = 1'b0;
        data_i = 32'hDEAD_BEEF;
        lat    = 1;
        while (!v_o && lat < 20) begin
            tick();
            lat++;
        end
        if (!v_o) lat = -1;
    endtask

    // Consume the result; returns ready_o observed in the cycle after yumi.
    task automatic consume(output logic rdy);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        rdy = ready_o;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        data_i    = '0;
        yumi_i    = 1'b0;
        #2;
        checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: v_o=%b ready_o=%b required 0/0", v_o, ready_o);
        end
        tick();
        tick();
        checks++;
        if (data_o !== 32'h0 || shamt_o !== 6'd0 || zero_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: data=%h shamt=%0d zero=%b required 0/0/0", data_o, shamt_o, zero_o);
        end
        reset_n_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready_o=%b v_o=%b required 1/0", ready_o, v_o);
        end
        $display("test_reset done");
    endtask

    // Run one operand and check latency, result fields and handshake.
    task automatic test_vector(input string name, input logic [31:0] d,
                               input int exp_lat, input logic [31:0] exp_data,
                               input logic [5:0] exp_shamt, input logic exp_zero);
        int   lat;
        logic rdy_in;
        logic rdy_after;
        launch(d, lat, rdy_in);
        checks++;
        if (rdy_in !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_in: ready_o=%b required 1", name, rdy_in);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (data_o !== exp_data || shamt_o !== exp_shamt || zero_o !== exp_zero || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: data=%h shamt=%0d zero=%b ready=%b required %h/%0d/%b/0",
                     name, data_o, shamt_o, zero_o, ready_o, exp_data, exp_shamt, exp_zero);
        end
        consume(rdy_after);
        checks++;
        if (rdy_after !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: ready_o=%b v_o=%b required 1/0", name, rdy_after, v_o);
        end
        $display("%s: in=%h lat=%0d data=%h shamt=%0d zero=%b", name, d, lat, data_o, shamt_o, zero_o);
    endtask

    task automatic test_msb_set();
        test_vector("msb_set", 32'h8000_0000, 2, 32'h8000_0000, 6'd0, 1'b0);
    endtask

    task automatic test_max_shift();
        test_vector("max_shift", 32'h0000_0001, 5, 32'h8000_0000, 6'd31, 1'b0);
    endtask

    task automatic test_step_boundary();
        test_vector("step_boundary", 32'h00F0_0000, 3, 32'hF000_0000, 6'd8, 1'b0);
    endtask

    task automatic test_zero();
        test_vector("zero_input", 32'h0000_0000, 1, 32'h0000_0000, 6'd32, 1'b1);
    endtask

    task automatic test_back_to_back();
        test_vector("b2b_l30", 32'h0000_0003, 5, 32'hC000_0000, 6'd30, 1'b0);
        test_vector("b2b_l15", 32'h0001_8000, 3, 32'hC000_0000, 6'd15, 1'b0);
        test_vector("b2b_l1",  32'h7FFF_FFFF, 2, 32'hFFFF_FFFE, 6'd1,  1'b0);
        test_vector("b2b_l16", 32'h0000_FFFF, 4, 32'hFFFF_0000, 6'd16, 1'b0);
    endtask

    task automatic test_backpressure();
        int   lat;
        int   bad;
        logic rdy_in;
        logic rdy_after;
        launch(32'h0000_0A00, lat, rdy_in);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL bp_latency: got %0d required 4", lat);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            v_i    = i[0];
            data_i = 32'h0000_1111 * (i + 1);
            tick();
            if (v_o !== 1'b1 || ready_o !== 1'b0 || data_o !== 32'hA000_0000 ||
                shamt_o !== 6'd20 || zero_o !== 1'b0) bad++;
        end
        v_i = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, last data=%h shamt=%0d v=%b ready=%b required a0000000/20/1/0",
                     bad, data_o, shamt_o, v_o, ready_o);
        end
        consume(rdy_after);
        checks++;
        if (rdy_after !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_yumi: ready_o=%b required 1", rdy_after);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (v_o !== 1'b0 || ready_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_no_phantom: %0d cycles with v_o=%b ready_o=%b required 0/1", bad, v_o, ready_o);
        end
        $display("test_backpressure: data=%h shamt=%0d", data_o, shamt_o);
    endtask

    task automatic test_reset_mid();
        logic rdy_in;
        rdy_in = ready_o;
        v_i    = 1'b1;
        data_i = 32'h0000_0001;
        tick();
        v_i = 1'b0;
        tick();
        checks++;
        if (rdy_in !== 1'b1 || ready_o !== 1'b0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_in_shift: ready_in=%b ready=%b v_o=%b required 1/0/0", rdy_in, ready_o, v_o);
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b0 || data_o !== 32'h0 || shamt_o !== 6'd0 || zero_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_during_reset: v=%b ready=%b data=%h shamt=%0d zero=%b required all 0",
                     v_o, ready_o, data_o, shamt_o, zero_o);
        end
        tick();
        tick();
        reset_n_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release: ready=%b v_o=%b required 1/0", ready_o, v_o);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_discarded: v_o=%b required 0", v_o);
        end
        $display("test_reset_mid: reset pulse applied mid-shift");
        test_vector("rmid_fresh", 32'h0000_0100, 4, 32'h8000_0000, 6'd23, 1'b0);
    endtask

    initial begin
        test_reset();
        test_msb_set();
        test_max_shift();
        test_step_boundary();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
